// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Read-domain consumer for the dual-clock fifo. A start pulse pops exactly
// burst_len words from the show-ahead FIFO read port. Each word is presented
// downstream on a valid/ready handshake through a two-entry buffer (main + skid).
// A buffer that never holds more than two words means that downstream
// back-pressure cannot drop a word and cannot over-read the FIFO.
//
// Optional feature: define FIFO_BURST_READER_ABORT_EN to add the 'abort' input.
// An abort ends an active burst at the next edge and discards any buffered words.
//
// Ports
//   rclk        read-domain clock (rising edge)
//   rrst        asynchronous active-high reset
//   start       burst request; sampled only in IDLE
//   burst_len   number of words to pop; sampled with start
//   rdata       FIFO read data (show-ahead, valid while rempty=0)
//   rempty      FIFO empty flag
//   rinc        FIFO pop strobe (combinational)
//   dout        output word
//   dout_valid  dout holds a word
//   dout_ready  downstream accepts; transfer = dout_valid & dout_ready
//   busy        burst in progress (READ or DRAIN)
//   done        one-cycle pulse at the end of a burst
//   remaining   words still to be popped in the current burst
//   abort       (FIFO_BURST_READER_ABORT_EN only) terminate the active burst
module fifo_burst_reader #(
    parameter int unsigned DSIZE = 5,
    parameter int unsigned LSIZE = 5
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             start,
    input  logic [LSIZE-1:0] burst_len,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic [DSIZE-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic [LSIZE-1:0] remaining
`ifdef FIFO_BURST_READER_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [DSIZE-1:0] skid_q;
    logic             skid_v;

    logic [DSIZE-1:0] main_nxt;
    logic             main_v_nxt;
    logic [DSIZE-1:0] skid_nxt;
    logic             skid_v_nxt;
    logic [LSIZE-1:0] rem_nxt;
    logic             done_nxt;

    logic [1:0]       cnt;
    logic             xfer;
    logic             abort_act;

    // Buffer occupancy and downstream transfer.
    assign cnt  = {1'b0, dout_valid} + {1'b0, skid_v};
    assign xfer = dout_valid & dout_ready;

    // Abort only acts while a burst is running.
`ifdef FIFO_BURST_READER_ABORT_EN
    assign abort_act = abort & (state != IDLE);
`else
    assign abort_act = 1'b0;
`endif

    // Next-state, pop strobe and buffer steering.
    always_comb begin
        state_nxt  = state;
        rem_nxt    = remaining;
        done_nxt   = 1'b0;
        main_nxt   = dout;
        main_v_nxt = dout_valid;
        skid_nxt   = skid_q;
        skid_v_nxt = skid_v;
        rinc       = 1'b0;

        // cnt<2 guarantees the popped word always has a free slot.
        rinc = (state == READ) && !rempty && (remaining != '0) &&
               (cnt < 2'd2) && !abort_act;

        // A word leaving main is replaced by skid if present, else by the new pop.
        if (xfer) begin
            if (skid_v) begin
                main_nxt = skid_q;
                if (rinc) begin
                    skid_nxt = rdata;
                end else begin
                    skid_v_nxt = 1'b0;
                end
            end else if (rinc) begin
                main_nxt = rdata;
            end else begin
                main_v_nxt = 1'b0;
            end
        end else if (rinc) begin
            if (!dout_valid) begin
                main_nxt   = rdata;
                main_v_nxt = 1'b1;
            end else begin
                skid_nxt   = rdata;
                skid_v_nxt = 1'b1;
            end
        end

        if (rinc) begin
            rem_nxt = remaining - LSIZE'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        rem_nxt   = burst_len;
                        state_nxt = READ;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            READ: begin
                if (rinc && (remaining == LSIZE'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Burst ends when the last buffered word has been accepted.
                if (!main_v_nxt) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort_act) begin
            state_nxt  = IDLE;
            rem_nxt    = '0;
            main_v_nxt = 1'b0;
            skid_v_nxt = 1'b0;
            done_nxt   = 1'b1;
        end
    end

    // State, buffer and status registers.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state      <= IDLE;
            remaining  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            skid_q     <= '0;
            skid_v     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            remaining  <= rem_nxt;
            dout       <= main_nxt;
            dout_valid <= main_v_nxt;
            skid_q     <= skid_nxt;
            skid_v     <= skid_v_nxt;
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural show-ahead FIFO.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_fifo_burst_reader;

    localparam int unsigned DSIZE = 5;
    localparam int unsigned LSIZE = 5;

    logic             rclk;
    logic             rrst;
    logic             start;
    logic [LSIZE-1:0] burst_len;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic [DSIZE-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             done;
    logic [LSIZE-1:0] remaining;
`ifdef FIFO_BURST_READER_ABORT_EN
    logic             abort;
`endif

    int errors;
    int checks;

    // FIFO model: mem[i] holds the word i; pointers are plain counters.
    logic [DSIZE-1:0] mem [0:63];
    int rd_ptr;
    int wr_ptr;

    assign rdata  = mem[rd_ptr[5:0]];
    assign rempty = (rd_ptr == wr_ptr);

    always @(posedge rclk) begin
        if (rinc) rd_ptr <= rd_ptr + 1;
    end

    fifo_burst_reader #(.DSIZE(DSIZE), .LSIZE(LSIZE)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .start      (start),
        .burst_len  (burst_len),
        .rdata      (rdata),
        .rempty     (rempty),
        .rinc       (rinc),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
`ifdef FIFO_BURST_READER_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[5:0]] = DSIZE'(wr_ptr);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rd_ptr     = 0;
        wr_ptr     = 0;
        rrst       = 1'b1;
        start      = 1'b0;
        burst_len  = '0;
        dout_ready = 1'b1;
`ifdef FIFO_BURST_READER_ABORT_EN
        abort      = 1'b0;
`endif
        for (int i = 0; i < 64; i++) mem[i] = '0;
        push(10);

        // Reset state.
        #7;
        chk("rst_rinc", rinc, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_remaining", remaining, 0);
        @(negedge rclk);
        rrst = 1'b0;
        @(negedge rclk);

        // Normal burst of 4: one pop per cycle, words 0..3.
        start = 1'b1; burst_len = 5'd4;
        @(negedge rclk);
        start = 1'b0;
        chk("n_busy", busy, 1);
        chk("n_rem_load", remaining, 4);
        chk("n_first_valid", dout_valid, 0);
        for (int i = 0; i < 4; i++) begin
            chk("n_rinc", rinc, 1);
            if (i > 0) begin
                chk("n_dout", dout, 32'(i - 1));
                chk("n_valid", dout_valid, 1);
            end
            @(negedge rclk);
        end
        chk("n_drain_rinc", rinc, 0);
        chk("n_last_dout", dout, 3);
        chk("n_drain_done", done, 0);
        @(negedge rclk);
        chk("n_done", done, 1);
        chk("n_busy_end", busy, 0);
        chk("n_valid_end", dout_valid, 0);
        chk("n_popped", 32'(rd_ptr), 4);
        @(negedge rclk);
        chk("n_done_pulse", done, 0);

        // Back-pressure: burst of 6 (words 4..9) with ready low for 5 cycles.
        dout_ready = 1'b0;
        start = 1'b1; burst_len = 5'd6;
        @(negedge rclk);
        start = 1'b0;
        chk("bp_rinc1", rinc, 1);
        @(negedge rclk);
        chk("bp_rinc2", rinc, 1);
        chk("bp_dout", dout, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            chk("bp_stall_rinc", rinc, 0);
            chk("bp_hold_dout", dout, 4);
            chk("bp_hold_valid", dout_valid, 1);
        end
        chk("bp_pops", 32'(rd_ptr), 6);
        chk("bp_rem", remaining, 4);
        dout_ready = 1'b1;
        for (int k = 5; k < 10; k++) begin
            @(negedge rclk);
            chk("bp_dout_seq", dout, 32'(k));
            chk("bp_valid_seq", dout_valid, 1);
            chk("bp_no_early_done", done, 0);
        end
        @(negedge rclk);
        chk("bp_done", done, 1);
        @(negedge rclk);
        chk("bp_done_once", done, 0);
        chk("bp_popped", 32'(rd_ptr), 10);

        // Starved FIFO: burst of 3 waits until words 10..12 are written.
        start = 1'b1; burst_len = 5'd3;
        @(negedge rclk);
        start = 1'b0;
        chk("st_busy", busy, 1);
        chk("st_rinc_a", rinc, 0);
        @(negedge rclk);
        chk("st_rinc_b", rinc, 0);
        chk("st_rem", remaining, 3);
        push(3);
        @(negedge rclk);
        chk("st_dout0", dout, 10);
        chk("st_rinc_c", rinc, 1);
        @(negedge rclk);
        chk("st_dout1", dout, 11);
        chk("st_rem1", remaining, 1);
        @(negedge rclk);
        chk("st_dout2", dout, 12);
        chk("st_rinc_d", rinc, 0);
        @(negedge rclk);
        chk("st_done", done, 1);
        chk("st_popped", 32'(rd_ptr), 13);

        // Zero-length request: done next cycle, no pop, never busy.
        push(10);
        @(negedge rclk);
        start = 1'b1; burst_len = 5'd0;
        @(negedge rclk);
        start = 1'b0;
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_rinc", rinc, 0);
        @(negedge rclk);
        chk("z_done_pulse", done, 0);
        chk("z_popped", 32'(rd_ptr), 13);

        // Reset after two pops of an 8-word burst, then a 2-word burst.
        start = 1'b1; burst_len = 5'd8;
        @(negedge rclk);
        start = 1'b0;
        @(negedge rclk);
        chk("r_dout13", dout, 13);
        @(negedge rclk);
        chk("r_dout14", dout, 14);
        chk("r_rem", remaining, 6);
        #1 rrst = 1'b1;
        #1;
        chk("r_async_dout", dout, 0);
        chk("r_async_valid", dout_valid, 0);
        chk("r_async_busy", busy, 0);
        chk("r_async_rem", remaining, 0);
        chk("r_async_rinc", rinc, 0);
        rrst = 1'b0;
        @(negedge rclk);
        chk("r_popped", 32'(rd_ptr), 15);
        start = 1'b1; burst_len = 5'd2;
        @(negedge rclk);
        start = 1'b0;
        chk("r2_rinc", rinc, 1);
        @(negedge rclk);
        chk("r2_dout15", dout, 15);
        @(negedge rclk);
        chk("r2_dout16", dout, 16);
        @(negedge rclk);
        chk("r2_done", done, 1);
        chk("r2_popped", 32'(rd_ptr), 17);

`ifdef FIFO_BURST_READER_ABORT_EN
        // Abort on the third READ cycle of an 8-word burst.
        push(4);
        @(negedge rclk);
        start = 1'b1; burst_len = 5'd8;
        @(negedge rclk);
        start = 1'b0;
        chk("a_rinc1", rinc, 1);
        @(negedge rclk);
        chk("a_dout17", dout, 17);
        @(negedge rclk);
        abort = 1'b1;
        #1;
        chk("a_rinc_blocked", rinc, 0);
        @(negedge rclk);
        abort = 1'b0;
        chk("a_done", done, 1);
        chk("a_valid", dout_valid, 0);
        chk("a_rem", remaining, 0);
        chk("a_busy", busy, 0);
        chk("a_popped", 32'(rd_ptr), 19);
        @(negedge rclk);
        chk("a_done_pulse", done, 0);
        chk("a_idle_rinc", rinc, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
